// File: rtl/soc_ahb32sram_arb2.sv
// soc_ahb32sram_arb2: two-master AHB3-Lite arbiter in front of the single-port
// SRAM bridge. Master 0 is the instruction port, master 1 the data port.
// Round-robin on contention, grant held through bursts and locked sequences,
// responses steered to the master that owns the current data phase.
module soc_ahb32sram_arb2 #(
  parameter int XLEN = 32,
  parameter int PLEN = 32
) (
  input  logic                ahb3_clk_i,
  input  logic                ahb3_rst_i,
  input  logic [1:0]          mst_hsel_i,
  input  logic [2*PLEN-1:0]   mst_haddr_i,
  input  logic [2*XLEN-1:0]   mst_hwdata_i,
  input  logic [5:0]          mst_hburst_i,
  input  logic [2*(XLEN/8)-1:0] mst_hprot_i,
  input  logic [1:0]          mst_hwrite_i,
  input  logic [3:0]          mst_htrans_i,
  input  logic [1:0]          mst_hmastlock_i,
  output logic [2*XLEN-1:0]   mst_hrdata_o,
  output logic [1:0]          mst_hready_o,
  output logic [1:0]          mst_hresp_o,
  output logic                slv_hsel_o,
  output logic [PLEN-1:0]     slv_haddr_o,
  output logic [XLEN-1:0]     slv_hwdata_o,
  output logic                slv_hwrite_o,
  output logic [2:0]          slv_hburst_o,
  output logic [(XLEN/8)-1:0] slv_hprot_o,
  output logic [1:0]          slv_htrans_o,
  output logic                slv_hmastlock_o,
  input  logic [XLEN-1:0]     slv_hrdata_i,
  input  logic                slv_hready_i,
  input  logic                slv_hresp_i
);

  localparam int SW = XLEN / 8;

  // Owner encoding: IDLE means nobody holds the address bus.
  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_M0   = 2'd1;
  localparam logic [1:0] OWN_M1   = 2'd2;

  // Per-master views of the packed master buses.
  logic [PLEN-1:0] m_addr  [2];
  logic [XLEN-1:0] m_wdata [2];
  logic [2:0]      m_burst [2];
  logic [SW-1:0]   m_prot  [2];
  logic [1:0]      m_trans [2];
  logic [1:0]      req;

  logic [1:0] owner_q, owner_d;
  logic       last_q, last_d;
  logic       dph_vld_q, dph_vld_d;
  logic       dph_own_q, dph_own_d;

  logic       hold;
  logic [1:0] gnt;
  logic [1:0] sel;
  logic       own_idx;
  logic       gnt_idx;
  logic       sel_idx;

  assign own_idx = (owner_q == OWN_M1);
  assign gnt_idx = (gnt == OWN_M1);
  assign sel_idx = (sel == OWN_M1);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mst
      localparam logic [1:0] OWN_ME = (gi == 0) ? OWN_M0 : OWN_M1;
      localparam logic       IDX_ME = (gi == 1);
      logic addr_own;
      logic data_own;

      assign m_addr[gi]  = mst_haddr_i[gi*PLEN +: PLEN];
      assign m_wdata[gi] = mst_hwdata_i[gi*XLEN +: XLEN];
      assign m_burst[gi] = mst_hburst_i[gi*3 +: 3];
      assign m_prot[gi]  = mst_hprot_i[gi*SW +: SW];
      assign m_trans[gi] = mst_htrans_i[gi*2 +: 2];
      // A request is any NONSEQ or SEQ transfer while selected.
      assign req[gi]     = mst_hsel_i[gi] & m_trans[gi][1];

      assign addr_own = (sel == OWN_ME);
      assign data_own = dph_vld_q & (dph_own_q == IDX_ME);

      // Owners follow the slave; losers with a pending request are stalled.
      assign mst_hready_o[gi] = (addr_own | data_own) ? slv_hready_i : ~req[gi];
      assign mst_hresp_o[gi]  = slv_hresp_i & data_own;
      // Read data is broadcast; only the data-phase owner samples it.
      assign mst_hrdata_o[gi*XLEN +: XLEN] = slv_hrdata_i;
    end
  endgenerate

  // State register: owner, round-robin pointer and data-phase tracking.
  always_ff @(posedge ahb3_clk_i or posedge ahb3_rst_i) begin
    if (ahb3_rst_i) begin
      owner_q   <= OWN_IDLE;
      last_q    <= 1'b1;  // master 0 wins the first tie
      dph_vld_q <= 1'b0;
      dph_own_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      dph_vld_q <= dph_vld_d;
      dph_own_q <= dph_own_d;
    end
  end

  // Next state: grant decision, advanced only when the slave accepts.
  always_comb begin
    // The owner keeps the bus mid-burst (BUSY/SEQ) or while locked.
    hold = (owner_q != OWN_IDLE) & (m_trans[own_idx][0] | mst_hmastlock_i[own_idx]);
    gnt  = OWN_IDLE;
    if (hold) begin
      gnt = owner_q;
    end else begin
      case (req)
        2'b01:   gnt = OWN_M0;
        2'b10:   gnt = OWN_M1;
        2'b11:   gnt = last_q ? OWN_M0 : OWN_M1;
        default: gnt = OWN_IDLE;
      endcase
    end
    owner_d   = owner_q;
    last_d    = last_q;
    dph_vld_d = dph_vld_q;
    dph_own_d = dph_own_q;
    if (slv_hready_i) begin
      owner_d   = gnt;
      if (gnt != OWN_IDLE) last_d = gnt_idx;
      dph_vld_d = (gnt != OWN_IDLE) & req[gnt_idx];
      dph_own_d = gnt_idx;
    end
  end

  // Outputs: address mux (frozen on the owner while the slave stalls), wdata mux.
  always_comb begin
    sel             = slv_hready_i ? gnt : owner_q;
    slv_hsel_o      = 1'b0;
    slv_haddr_o     = '0;
    slv_hwrite_o    = 1'b0;
    slv_hburst_o    = 3'b000;
    slv_hprot_o     = '0;
    slv_htrans_o    = 2'b00;
    slv_hmastlock_o = 1'b0;
    if (sel != OWN_IDLE) begin
      slv_hsel_o      = mst_hsel_i[sel_idx];
      slv_haddr_o     = m_addr[sel_idx];
      slv_hwrite_o    = mst_hwrite_i[sel_idx];
      slv_hburst_o    = m_burst[sel_idx];
      slv_hprot_o     = m_prot[sel_idx];
      slv_htrans_o    = m_trans[sel_idx];
      slv_hmastlock_o = mst_hmastlock_i[sel_idx];
    end
    slv_hwdata_o = dph_vld_q ? m_wdata[dph_own_q] : '0;
  end

endmodule

// File: tb/tb_soc_ahb32sram_arb2.sv
// Testbench for soc_ahb32sram_arb2: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_soc_ahb32sram_arb2;
  localparam int XLEN = 32;
  localparam int PLEN = 32;
  localparam int SW   = 4;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]  hsel, hwrite, hlock;
  logic [63:0] haddr, hwdata;
  logic [5:0]  hburst;
  logic [7:0]  hprot;
  logic [3:0]  htrans;
  logic [63:0] hrdata;
  logic [1:0]  hready, hresp;

  logic        s_hsel, s_hwrite, s_hlock;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic [2:0]  s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;
  logic        s_hready, s_hresp;

  soc_ahb32sram_arb2 #(.XLEN(XLEN), .PLEN(PLEN)) dut (
    .ahb3_clk_i(clk), .ahb3_rst_i(rst),
    .mst_hsel_i(hsel), .mst_haddr_i(haddr), .mst_hwdata_i(hwdata),
    .mst_hburst_i(hburst), .mst_hprot_i(hprot), .mst_hwrite_i(hwrite),
    .mst_htrans_i(htrans), .mst_hmastlock_i(hlock),
    .mst_hrdata_o(hrdata), .mst_hready_o(hready), .mst_hresp_o(hresp),
    .slv_hsel_o(s_hsel), .slv_haddr_o(s_haddr), .slv_hwdata_o(s_hwdata),
    .slv_hwrite_o(s_hwrite), .slv_hburst_o(s_hburst), .slv_hprot_o(s_hprot),
    .slv_htrans_o(s_htrans), .slv_hmastlock_o(s_hlock),
    .slv_hrdata_i(s_hrdata), .slv_hready_i(s_hready), .slv_hresp_i(s_hresp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    else
      n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // owner: -1 = nobody, else master number; last: master granted most recently;
  // dvld/down: a real transfer is in its data phase, owned by master down.
  int m_owner = -1, m_last = 1, m_down = 0;
  bit m_dvld = 1'b0;
  int n_owner = -1, n_last = 1, n_down = 0;
  bit n_dvld = 1'b0;

  function automatic bit req_of(input int i);
    return hsel[i] && (htrans[i*2 +: 2] inside {NONSEQ, SEQ});
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_last <= 1; m_dvld <= 1'b0; m_down <= 0;
    end else begin
      m_owner <= n_owner; m_last <= n_last; m_dvld <= n_dvld; m_down <= n_down;
    end
  end

  // Compare the DUT against the model once per cycle, away from the clock edge.
  always @(negedge clk) begin
    int g, sel;
    bit keep;
    logic [1:0]  e_ready, e_resp;
    logic [31:0] e_wdata;
    keep = (m_owner >= 0) &&
           ((htrans[m_owner*2 +: 2] inside {BUSY, SEQ}) || hlock[m_owner]);
    if (keep)                         g = m_owner;
    else if (req_of(0) && req_of(1))  g = 1 - m_last;
    else if (req_of(0))               g = 0;
    else if (req_of(1))               g = 1;
    else                              g = -1;
    sel = s_hready ? g : m_owner;
    for (int i = 0; i < 2; i++) begin
      if (sel == i || (m_dvld && m_down == i)) e_ready[i] = s_hready;
      else                                     e_ready[i] = !req_of(i);
      e_resp[i] = s_hresp && m_dvld && m_down == i;
    end
    e_wdata = m_dvld ? hwdata[m_down*32 +: 32] : 32'h0;
    if (chk_en) begin
      if (sel < 0) begin
        check("slv_hsel", 64'(s_hsel), 64'(0));
        check("slv_htrans", 64'(s_htrans), 64'(0));
        check("slv_haddr", 64'(s_haddr), 64'(0));
        check("slv_ctrl", 64'({s_hwrite, s_hburst, s_hprot, s_hlock}), 64'(0));
      end else begin
        check("slv_hsel", 64'(s_hsel), 64'(hsel[sel]));
        check("slv_htrans", 64'(s_htrans), 64'(htrans[sel*2 +: 2]));
        check("slv_haddr", 64'(s_haddr), 64'(haddr[sel*32 +: 32]));
        check("slv_ctrl", 64'({s_hwrite, s_hburst, s_hprot, s_hlock}),
              64'({hwrite[sel], hburst[sel*3 +: 3], hprot[sel*4 +: 4], hlock[sel]}));
      end
      check("slv_hwdata", 64'(s_hwdata), 64'(e_wdata));
      check("mst_hready", 64'(hready), 64'(e_ready));
      check("mst_hresp", 64'(hresp), 64'(e_resp));
      check("mst_hrdata", hrdata, {s_hrdata, s_hrdata});
    end
    if (s_hready) begin
      n_owner <= g;
      n_last  <= (g >= 0) ? g : m_last;
      n_dvld  <= (g >= 0) && req_of(g);
      n_down  <= (g >= 0) ? g : 0;
    end else begin
      n_owner <= m_owner; n_last <= m_last; n_dvld <= m_dvld; n_down <= m_down;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_all();
    hsel = 2'b00; htrans = 4'h0; hwrite = 2'b00; hlock = 2'b00; hburst = 6'h0;
  endtask

  task automatic set_m(input int i, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic lk, input logic [2:0] bu);
    hsel[i] = 1'b1; htrans[i*2 +: 2] = tr; haddr[i*32 +: 32] = a;
    hwrite[i] = wr; hlock[i] = lk; hburst[i*3 +: 3] = bu; hprot[i*4 +: 4] = 4'hF;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    s_hrdata = $urandom;
  endtask

  initial begin
    idle_all();
    haddr = '0; hwdata = '0; hprot = '0;
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hready", 64'(hready), 64'(2'b11));
    check("rst_hresp", 64'(hresp), 64'(0));
    check("rst_hsel_htrans", 64'({s_hsel, s_htrans}), 64'(0));
    rst = 1'b0;
    chk_en = 1'b1;

    // Contention right after reset: master 0 first, master 1 next.
    cyc(); set_m(0, NONSEQ, 32'h200, 0, 0, 0); set_m(1, NONSEQ, 32'h300, 0, 0, 0); #3;
    check("t2_haddr_m0", 64'(s_haddr), 64'h200);
    check("t2_hready", 64'(hready), 64'(2'b01));
    cyc(); idle_all(); set_m(1, NONSEQ, 32'h300, 0, 0, 0); #3;
    check("t2_haddr_m1", 64'(s_haddr), 64'h300);
    check("t2_hready2", 64'(hready), 64'(2'b11));
    cyc(); idle_all();

    // Lone master 0 read: same-cycle address, nobody stalled.
    cyc(); set_m(0, NONSEQ, 32'h100, 0, 0, 0); #3;
    check("t1_haddr", 64'(s_haddr), 64'h100);
    check("t1_hready", 64'(hready), 64'(2'b11));
    cyc(); idle_all();

    // Master 1 single so master 0 wins the next tie, then INCR4 vs. master 1.
    cyc(); set_m(1, NONSEQ, 32'h480, 0, 0, 0);
    cyc(); idle_all();
    for (int b = 0; b < 4; b++) begin
      cyc();
      set_m(0, (b == 0) ? NONSEQ : SEQ, 32'h400 + 32'(4*b), 0, 0, 3'b011);
      set_m(1, NONSEQ, 32'h500, 0, 0, 0); #3;
      check("t3_burst_haddr", 64'(s_haddr), 64'(32'h400 + 32'(4*b)));
      check("t3_m1_stall", 64'(hready[1]), 64'(0));
    end
    cyc(); hsel[0] = 1'b0; htrans[1:0] = IDLE; #3;
    check("t3_m1_haddr", 64'(s_haddr), 64'h500);
    cyc(); idle_all();

    // Locked read-modify-write by master 1 with an IDLE in between.
    cyc(); set_m(1, NONSEQ, 32'h600, 0, 1, 0); #3;
    check("t4_lock_out", 64'({s_hlock, s_haddr}), 64'({1'b1, 32'h600}));
    cyc(); set_m(1, IDLE, 32'h600, 0, 1, 0); set_m(0, NONSEQ, 32'h700, 0, 0, 0); #3;
    check("t4_m0_stall_a", 64'(hready[0]), 64'(0));
    cyc(); set_m(1, NONSEQ, 32'h600, 1, 1, 0); #3;
    check("t4_m0_stall_b", 64'(hready[0]), 64'(0));
    check("t4_haddr", 64'(s_haddr), 64'h600);
    cyc(); set_m(1, IDLE, 32'h600, 0, 0, 0); hwdata[63:32] = 32'hAAAA0001; #3;
    check("t4_m0_gnt", 64'(s_haddr), 64'h700);
    check("t4_wdata_m1", 64'(s_hwdata), 64'hAAAA0001);
    cyc(); idle_all();

    // Slave wait states during a master 0 write data phase.
    cyc(); set_m(0, NONSEQ, 32'h800, 1, 0, 0);
    for (int w = 0; w < 3; w++) begin
      cyc(); set_m(0, IDLE, 32'h800, 0, 0, 0); hwdata[31:0] = 32'hDEAD0800;
      set_m(1, NONSEQ, 32'h900, 0, 0, 0); s_hready = 1'b0; #3;
      check("t5_haddr_frozen", 64'(s_haddr), 64'h800);
      check("t5_hready", 64'(hready), 64'(2'b00));
      check("t5_wdata", 64'(s_hwdata), 64'hDEAD0800);
    end
    cyc(); s_hready = 1'b1; #3;
    check("t5_m1_gnt", 64'(s_haddr), 64'h900);
    check("t5_hready_rel", 64'(hready), 64'(2'b11));

    // Error response in master 1 data phase, then reset mid-burst.
    cyc(); idle_all(); s_hresp = 1'b1; #3;
    check("t6_hresp", 64'(hresp), 64'(2'b10));
    check("t6_hrdata", hrdata, {s_hrdata, s_hrdata});
    cyc(); s_hresp = 1'b0; hwdata[31:0] = 32'h12345678;
    set_m(0, NONSEQ, 32'hA00, 0, 0, 3'b011); set_m(1, NONSEQ, 32'hB00, 0, 0, 0);
    cyc(); set_m(0, SEQ, 32'hA04, 0, 0, 3'b011); s_hresp = 1'b1; #2;
    rst = 1'b1; #1;
    check("t6_rst_hresp", 64'(hresp), 64'(0));
    check("t6_rst_wdata", 64'(s_hwdata), 64'(0));
    check("t6_rst_m1_stall", 64'(hready), 64'(2'b01));
    idle_all(); s_hresp = 1'b0; #1;
    check("t6_rst_hready", 64'(hready), 64'(2'b11));
    check("t6_rst_slv", 64'({s_hsel, s_htrans}), 64'(0));
    repeat (2) cyc();
    rst = 1'b0;

    // Randomized traffic, checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        hsel[i]            = ($urandom_range(0, 4) != 0);
        htrans[i*2 +: 2]   = 2'($urandom_range(0, 3));
        haddr[i*32 +: 32]  = $urandom & 32'hFFFF_FFFC;
        hwdata[i*32 +: 32] = $urandom;
        hwrite[i]          = 1'($urandom_range(0, 1));
        hlock[i]           = ($urandom_range(0, 7) == 0);
        hburst[i*3 +: 3]   = 3'($urandom_range(0, 7));
        hprot[i*4 +: 4]    = 4'($urandom_range(0, 15));
      end
      s_hready = ($urandom_range(0, 3) != 0);
      s_hresp  = ($urandom_range(0, 9) == 0);
    end
    cyc(); idle_all(); s_hready = 1'b1; s_hresp = 1'b0;
    repeat (2) cyc();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
